frame_loader: RTL and testbench
===============================

// Module: frame_loader
// PURPOSE
//  Upstream stage of lenet: takes a raster byte stream of 32x32 pixels, stores it in a
//  ping-pong (two-bank) pixel buffer and serves lenet's source read port (cena_src/aa_src/qa_src).
//  Pulses go once per full frame, holds the bank until lenet's ready, then frees it.
//  Replaces the bench-side src_rom and lets the loader accept frame N+1 while lenet runs frame N.
// PARAMETERS
//  PIX_W     8     input pixel width; zero-extended to `WD+1 on qa_src
//  FRAME_PIX 1024  pixels per frame (32*32); address width fixed at 10
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  rstn         in   1          asynchronous, active-low reset
//  s_valid      in   1          input pixel valid
//  s_data       in   PIX_W      input pixel, raster order, row 0 col 0 first
//  s_ready      out  1          loader accepts pixel this cycle (transfer = s_valid & s_ready)
//  go           out  1          one-cycle start pulse to lenet
//  cena_src     in   1          lenet read enable, active-low
//  aa_src       in   10         lenet read address
//  qa_src       out  `WD+1      read data, zero-extended pixel
//  ready        in   1          lenet done pulse (digit valid)
//  digit        in   4          lenet result
//  digit_out    out  4          registered result of last frame
//  digit_valid  out  1          one-cycle pulse, digit_out valid
//  frame_cnt    out  32         frames completed by lenet since reset
//  err_spurious out  1          sticky: ready seen while no frame in flight
// BEHAVIOUR
//  Reset (rstn low, async): both banks EMPTY, wr_bank=0, wr_ptr=0, state=IDLE; outputs
//   s_ready=0, go=0, qa_src=0, digit_out=0, digit_valid=0, frame_cnt=0, err_spurious=0.
//   Reset mid-frame discards all partial and full frames; RAM contents not cleared.
//  Bank status per bank: EMPTY -> FILLING -> FULL -> BUSY -> EMPTY.
//  Write side: s_ready = (bank[wr_bank] is EMPTY or FILLING), registered-free comb of status.
//   Each transfer writes s_data to bank[wr_bank][wr_ptr], wr_ptr++.
//   Transfer at wr_ptr==FRAME_PIX-1: bank -> FULL, wr_ptr wraps to 0, wr_bank toggles.
//   If the toggled-to bank is not EMPTY, s_ready drops next cycle (backpressure, no data loss).
//  Control FSM (IDLE, GO, BUSY):
//   IDLE: if a bank is FULL (oldest first, i.e. bank != wr_bank when both qualify) -> rd_bank=it,
//         bank -> BUSY, go=1 next cycle, state GO.
//   GO:   go=1 for exactly this one cycle -> BUSY.
//   BUSY: on ready: bank[rd_bank] -> EMPTY, digit_out<=digit, digit_valid=1 next cycle,
//         frame_cnt++ (wraps at 2^32), -> IDLE. Next go no earlier than 2 cycles after ready.
//  Read side: when !cena_src, qa_src <= {zero-ext, bank[rd_bank][aa_src]} on next edge
//   (1-cycle latency, same as a sync ROM); qa_src holds when cena_src high. Reads in IDLE
//   return rd_bank's stale data, no error.
//  Simultaneous events: bank fill and ready on same edge are both applied; freed bank becomes
//   writable next cycle. Write and read never hit the same bank (status guarantees).
//  ready in IDLE or GO: ignored for control, err_spurious <= 1 (cleared only by reset).
//  aa_src >= FRAME_PIX: address wraps modulo 1024 (10-bit), no error.
// STRUCTURE
//  Shared package lenet_pkg: FRAME_PIX, FRAME_W/H=32, bank_status_t enum
//   {EMPTY,FILLING,FULL,BUSY}, loader_state_t enum {IDLE,GO,BUSY}.
//  Sub-module pix_dpram (1024 x PIX_W, one sync write port, one sync read port with active-low
//   enable), instantiated twice; qa_src mux selects on rd_bank registered with the read.
// TESTING
//  1 Reset, stream 1024 pixels p[i]=i%256 with s_valid held high -> s_ready high for all 1024,
//    go pulses once 2 cycles after last transfer; read aa=9 -> qa_src=9 one cycle later.
//  2 Stream frame A, then frame B with lenet model holding ready low -> B fully accepted,
//    3rd frame's first pixel sees s_ready=0 until ready; after ready, go for B within 2 cycles,
//    reads return B data.
//  3 Random s_valid gaps (50%) over 3 frames -> no lost/duplicated pixel, frame_cnt=3,
//    digit_out tracks model digits 7,3,1 with digit_valid pulses 1 cycle after each ready.
//  4 Last pixel of frame B and ready for frame A on same edge -> A bank EMPTY, B go issued
//    next IDLE cycle, s_ready=1 the following cycle.
//  5 ready pulse with no frame loaded -> err_spurious=1, frame_cnt stays 0, no go.
//  6 Assert rstn low after 500 pixels of a frame and while BUSY -> all outputs to reset values
//    asynchronously; new full frame after release yields exactly one go and correct reads.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared constants and state encodings for the lenet front end.
package lenet_pkg;
  localparam int FRAME_W   = 32;
  localparam int FRAME_H   = 32;
  localparam int FRAME_PIX = FRAME_W * FRAME_H;
  localparam int AW        = 10;
  localparam int WD        = 15;

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILLING,
    B_FULL,
    B_BUSY
  } bank_status_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GO,
    S_BUSY
  } loader_state_t;
endpackage

// File: rtl/frame_loader_if.sv
// Raster pixel stream into the frame loader (valid/ready).
interface frame_loader_if #(
  parameter int PIX_W = 8
);
  logic             s_valid;
  logic [PIX_W-1:0] s_data;
  logic             s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/pix_dpram.sv
// One pixel bank: sync write port, sync read port with active-low enable.
module pix_dpram #(
  parameter int PIX_W = 8,
  parameter int AW    = 10
)(
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [PIX_W-1:0] wd,
  input  logic             cen,
  input  logic [AW-1:0]    ra,
  output logic [PIX_W-1:0] q
);
  logic [PIX_W-1:0] mem [1<<AW];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Output register resets so the read port reads back zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    q <= '0;
    else if (!cen) q <= mem[ra];
  end
endmodule

// File: rtl/frame_loader.sv
// Ping-pong frame buffer in front of lenet: fills one bank while lenet reads the other.
module frame_loader import lenet_pkg::*; #(
  parameter int PIX_W = 8
)(
  input  logic          clk,
  input  logic          rstn,
  frame_loader_if.slave s,
  output logic          go,
  input  logic          cena_src,
  input  logic [AW-1:0] aa_src,
  output logic [WD:0]   qa_src,
  input  logic          ready,
  input  logic [3:0]    digit,
  output logic [3:0]    digit_out,
  output logic          digit_valid,
  output logic [31:0]   frame_cnt,
  output logic          err_spurious
);
  bank_status_t          bank_st [2];
  loader_state_t         state;
  logic                  wr_bank, rd_bank, rd_sel, live;
  logic [AW-1:0]         wr_ptr;
  logic                  xfer, pick_ok, pick;
  logic [1:0][PIX_W-1:0] q;

  // live keeps s_ready low while reset is asserted even though both banks read EMPTY.
  assign s.s_ready = live && (bank_st[wr_bank] == B_EMPTY || bank_st[wr_bank] == B_FILLING);
  assign xfer      = s.s_valid && s.s_ready;

  // Oldest full bank is the one not currently targeted by the writer.
  always_comb begin
    pick_ok = 1'b1;
    pick    = ~wr_bank;
    if (bank_st[~wr_bank] == B_FULL)    pick = ~wr_bank;
    else if (bank_st[wr_bank] == B_FULL) pick = wr_bank;
    else                                 pick_ok = 1'b0;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pix_dpram #(.PIX_W(PIX_W), .AW(AW)) u_ram (
      .clk  (clk),
      .rstn (rstn),
      .we   (xfer && (wr_bank == 1'(b))),
      .wa   (wr_ptr),
      .wd   (s.s_data),
      .cen  (cena_src),
      .ra   (aa_src),
      .q    (q[b])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         rd_sel <= 1'b0;
    else if (!cena_src) rd_sel <= rd_bank;
  end

  assign qa_src = {{(WD + 1 - PIX_W){1'b0}}, q[rd_sel]};

  // Writer and FSM only ever touch different banks on a given edge, so both updates apply.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_st[0]   <= B_EMPTY;
      bank_st[1]   <= B_EMPTY;
      state        <= S_IDLE;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_ptr       <= '0;
      live         <= 1'b0;
      go           <= 1'b0;
      digit_out    <= '0;
      digit_valid  <= 1'b0;
      frame_cnt    <= '0;
      err_spurious <= 1'b0;
    end else begin
      live        <= 1'b1;
      digit_valid <= 1'b0;
      if (xfer) begin
        if (wr_ptr == AW'(FRAME_PIX - 1)) begin
          bank_st[wr_bank] <= B_FULL;
          wr_bank          <= ~wr_bank;
          wr_ptr           <= '0;
        end else begin
          bank_st[wr_bank] <= B_FILLING;
          wr_ptr           <= wr_ptr + 1'b1;
        end
      end
      if (ready && state != S_BUSY) err_spurious <= 1'b1;
      case (state)
        S_IDLE: if (pick_ok) begin
          rd_bank       <= pick;
          bank_st[pick] <= B_BUSY;
          go            <= 1'b1;
          state         <= S_GO;
        end
        S_GO: begin
          go    <= 1'b0;
          state <= S_BUSY;
        end
        S_BUSY: if (ready) begin
          bank_st[rd_bank] <= B_EMPTY;
          digit_out        <= digit;
          digit_valid      <= 1'b1;
          frame_cnt        <= frame_cnt + 1'b1;
          state            <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader: streaming, backpressure, handoff, error and reset cases.
module tb_frame_loader;
  import lenet_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        go, digit_valid, err_spurious;
  logic        cena_src = 1'b1;
  logic        ready = 1'b0;
  logic [9:0]  aa_src = '0;
  logic [WD:0] qa_src;
  logic [3:0]  digit = '0;
  logic [3:0]  digit_out;
  logic [31:0] frame_cnt;

  always #5 clk = ~clk;

  frame_loader_if #(.PIX_W(8)) s_if();

  frame_loader #(.PIX_W(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s            (s_if),
    .go           (go),
    .cena_src     (cena_src),
    .aa_src       (aa_src),
    .qa_src       (qa_src),
    .ready        (ready),
    .digit        (digit),
    .digit_out    (digit_out),
    .digit_valid  (digit_valid),
    .frame_cnt    (frame_cnt),
    .err_spurious (err_spurious)
  );

  int tests = 0, fails = 0;
  int ncyc = 0, go_cnt = 0, go_at = 0, stalls = 0;
  int t_mark, go_base;

  always @(negedge clk) begin
    ncyc++;
    if (go) begin
      go_cnt++;
      go_at = ncyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix(input int i, input int k);
    return 8'((i + 37 * k) % 256);
  endfunction

  task automatic push(input logic [7:0] d, input bit gap);
    int n = 0;
    if (gap && $urandom_range(1) == 1) tick();
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    while (!s_if.s_ready && n < 3000) begin
      tick();
      n++;
      stalls++;
    end
    if (n >= 3000) check("push_ready_timeout", 64'(s_if.s_ready), 64'd1);
    tick();
    s_if.s_valid = 1'b0;
  endtask

  task automatic push_frame(input int k, input bit gap, input int npix);
    for (int i = 0; i < npix; i++) push(pix(i, k), gap);
  endtask

  task automatic wait_go(input int target);
    int n = 0;
    while (go_cnt < target && n < 20) begin
      tick();
      n++;
    end
    check("go_count", 64'(go_cnt), 64'(target));
  endtask

  task automatic read_chk(input string tag, input int a, input logic [7:0] exp);
    cena_src = 1'b0;
    aa_src   = 10'(a);
    tick();
    cena_src = 1'b1;
    check(tag, 64'(qa_src), 64'(exp));
  endtask

  task automatic done(input logic [3:0] d);
    ready = 1'b1;
    digit = d;
    tick();
    ready = 1'b0;
    check("digit_valid_pulse", 64'(digit_valid), 64'd1);
    check("digit_out", 64'(digit_out), 64'(d));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    #2;
    check("rst_s_ready", 64'(s_if.s_ready), 64'd0);
    check("rst_go", 64'(go), 64'd0);
    check("rst_qa", 64'(qa_src), 64'd0);
    check("rst_digit_out", 64'(digit_out), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_err", 64'(err_spurious), 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("s_ready_after_rst", 64'(s_if.s_ready), 64'd1);

    // Single frame, continuous valid
    stalls = 0;
    push_frame(0, 1'b0, FRAME_PIX);
    t_mark = ncyc;
    check("t1_no_stall", 64'(stalls), 64'd0);
    wait_go(1);
    check("t1_go_latency", 64'(go_at), 64'(t_mark + 2));
    read_chk("t1_rd9", 9, 8'd9);
    read_chk("t1_rd1023", 1023, 8'd255);
    done(4'd5);
    check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    tick();
    check("t1_dv_low", 64'(digit_valid), 64'd0);

    // Two frames queued while lenet holds off, third frame backpressured
    stalls = 0;
    push_frame(1, 1'b0, FRAME_PIX);
    wait_go(2);
    push_frame(2, 1'b0, FRAME_PIX);
    check("t2_b_no_stall", 64'(stalls), 64'd0);
    s_if.s_valid = 1'b1;
    s_if.s_data  = pix(0, 3);
    for (int i = 0; i < 3; i++) begin
      check("t2_backpressure", 64'(s_if.s_ready), 64'd0);
      tick();
    end
    check("t2_no_extra_go", 64'(go_cnt), 64'd2);
    read_chk("t2_rd_a", 9, pix(9, 1));
    done(4'd2);
    s_if.s_valid = 1'b0;
    t_mark = ncyc;
    check("t2_frame_cnt", 64'(frame_cnt), 64'd2);
    check("t2_s_ready_back", 64'(s_if.s_ready), 64'd1);
    wait_go(3);
    check("t2_go_latency", 64'(go_at), 64'(t_mark + 2));
    read_chk("t2_rd_b", 9, pix(9, 2));

    // Last pixel of the filling bank and ready for the busy bank on the same edge
    push_frame(3, 1'b0, FRAME_PIX - 1);
    s_if.s_valid = 1'b1;
    s_if.s_data  = pix(FRAME_PIX - 1, 3);
    done(4'd4);
    s_if.s_valid = 1'b0;
    t_mark = ncyc;
    check("t4_frame_cnt", 64'(frame_cnt), 64'd3);
    check("t4_s_ready", 64'(s_if.s_ready), 64'd1);
    wait_go(4);
    check("t4_go_latency", 64'(go_at), 64'(t_mark + 2));
    read_chk("t4_rd_last", 1023, pix(1023, 3));
    read_chk("t4_rd9", 9, pix(9, 3));
    done(4'd6);
    check("t4_frame_cnt2", 64'(frame_cnt), 64'd4);
    check("t4_err_clear", 64'(err_spurious), 64'd0);
    read_chk("t4_addr_wrap", 9, pix(9, 3));

    // Spurious ready with nothing loaded
    do_reset();
    go_base = go_cnt;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    repeat (3) tick();
    check("t5_err", 64'(err_spurious), 64'd1);
    check("t5_frame_cnt", 64'(frame_cnt), 64'd0);
    check("t5_no_go", 64'(go_cnt), 64'(go_base));
    check("t5_dv", 64'(digit_valid), 64'd0);

    // Three frames with random valid gaps
    do_reset();
    check("t3_err_cleared", 64'(err_spurious), 64'd0);
    go_base = go_cnt;
    push_frame(4, 1'b1, FRAME_PIX);
    wait_go(go_base + 1);
    read_chk("t3_f0_rd", 100, pix(100, 4));
    push_frame(5, 1'b1, FRAME_PIX);
    done(4'd7);
    wait_go(go_base + 2);
    read_chk("t3_f1_rd0", 0, pix(0, 5));
    read_chk("t3_f1_rd1023", 1023, pix(1023, 5));
    push_frame(6, 1'b1, FRAME_PIX);
    done(4'd3);
    wait_go(go_base + 3);
    read_chk("t3_f2_rd511", 511, pix(511, 6));
    done(4'd1);
    check("t3_frame_cnt", 64'(frame_cnt), 64'd3);

    // Async reset mid-frame while BUSY
    push_frame(7, 1'b0, FRAME_PIX);
    wait_go(go_base + 4);
    read_chk("t6_pre_rd", 9, pix(9, 7));
    push_frame(8, 1'b0, 500);
    rstn = 1'b0;
    #2;
    check("t6_s_ready", 64'(s_if.s_ready), 64'd0);
    check("t6_go", 64'(go), 64'd0);
    check("t6_qa", 64'(qa_src), 64'd0);
    check("t6_digit_out", 64'(digit_out), 64'd0);
    check("t6_dv", 64'(digit_valid), 64'd0);
    check("t6_frame_cnt", 64'(frame_cnt), 64'd0);
    check("t6_err", 64'(err_spurious), 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    go_base = go_cnt;
    push_frame(9, 1'b0, FRAME_PIX);
    repeat (10) tick();
    check("t6_one_go", 64'(go_cnt), 64'(go_base + 1));
    read_chk("t6_rd9", 9, pix(9, 9));
    read_chk("t6_rd1023", 1023, pix(1023, 9));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
